mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
Multi-cycle signed multiply/divide engine in the datapath ALU stage. Operand A comes from the Y register, operand B comes from the shared 32-bit bus. The 64-bit result is written into the Z pair: zhigh feeds the bus Zhigh input and zlow feeds the Zlow input. The control unit pulses start, waits for done, then drives Zhighout/Zlowout to move results to HI/LO.

Parameters:
WIDTH, 32, operand width. Must be even and at least 4. The Z pair is 2*WIDTH bits.

Ports:
clock  in  1  rising-edge clock
clear  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
op  in  1  0 = signed MUL, 1 = signed DIV
a  in  WIDTH  multiplicand / dividend (from Y)
b  in  WIDTH  multiplier / divisor (from bus)
busy  out  1  operation in progress
done  out  1  one-cycle pulse; zhigh/zlow valid
zhigh  out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
zlow  out  WIDTH  MUL: product[W-1:0]; DIV: quotient
div_by_zero  out  1  set with done when DIV had b==0; cleared on next accepted start

Behaviour:
- Reset (clear high, asynchronous): state=IDLE; busy, done, zhigh, zlow, div_by_zero all 0. Clear mid-operation aborts it; no done is produced.
- States: IDLE, MUL, DIV, FIX, DONE.
- Edge S = the edge on which start=1 is sampled in IDLE.
  - a, b and op are latched at edge S; input changes after S are ignored.
  - busy goes high at edge S.
  - start in any state other than IDLE is ignored and not queued.
- MUL:
  - Radix-4 Booth (bit-pair recoding), WIDTH/2 iterations on edges S+1..S+WIDTH/2.
  - At edge S+WIDTH/2, zhigh/zlow are loaded with the full signed 2W-bit product, done=1, busy=0, state goes to DONE.
  - Latency is 16 edges for WIDTH=32.
- DIV with b != 0:
  - Non-restoring division on operand magnitudes, WIDTH iterations on edges S+1..S+WIDTH.
  - At edge S+WIDTH the state goes to FIX.
  - At edge S+WIDTH+1, FIX applies the final remainder correction and sign fix-up. The quotient truncates toward zero; the remainder takes the sign of the dividend. zlow=quotient, zhigh=remainder, done=1, busy=0.
  - Latency is 33 edges for WIDTH=32.
  - -2^(W-1) / -1 wraps: zlow=0x80000000, zhigh=0. No flag is raised.
- DIV with b == 0:
  - At edge S+1: zlow=all ones, zhigh=a, div_by_zero=1, done=1, busy=0.
- DONE: done is high for exactly one cycle. The next edge returns to IDLE and done=0.
  - A start present during the DONE cycle is ignored; a new start is accepted from IDLE only.
  - Minimum spacing between accepted starts is latency+2 edges.
- zhigh/zlow change only at the completing edge. They hold their value between operations and during a following operation until that operation's completing edge, so the bus may read Z while a new op runs.
- Internal accumulators are 2W+1 bits (Booth) and W+1 bits (division partial remainder) so no intermediate overflow occurs.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD), start at edge S -> done at S+16 only; zhigh=0xFFFFFFFF, zlow=0xFFFFFFEB; busy high for S..S+15.
- MUL a=b=0x80000000 -> zhigh=0x40000000, zlow=0x00000000. Then MUL a=0xB6, b=0xB6 -> zhigh=0, zlow=0x00008164.
- DIV a=0xB6, b=5 -> done at S+33; zlow=0x24, zhigh=0x2. DIV a=-7, b=2 -> zlow=0xFFFFFFFD, zhigh=0xFFFFFFFF. DIV a=0x80000000, b=-1 -> zlow=0x80000000, zhigh=0.
- DIV a=0x1234, b=0 -> done at S+1; div_by_zero=1, zlow=0xFFFFFFFF, zhigh=0x1234. The following MUL 2*3 clears div_by_zero and gives zlow=6.
- Start DIV, pulse start with op=0 at S+5 and change a/b mid-op -> second start ignored; result matches the original operands; exactly one done.
- Start MUL 5*5 after a prior result of 0x24, assert clear at S+8 -> all outputs 0 immediately, no done. A fresh start afterwards gives zlow=0x19 at S'+16.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide engine: radix-4 Booth multiply and
// non-restoring divide on magnitudes, result delivered as a hi/lo Z pair.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zhigh,
  output logic [WIDTH-1:0] zlow,
  output logic             div_by_zero
);

  localparam int PW = 2 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH:0]   mplr;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] a_q;
  logic             a_neg;
  logic             b_neg;

  logic [PW-1:0]    booth_term;
  logic [PW-1:0]    acc_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;

  // Booth digit from the current bit triple selects 0, +-M or +-2M; mcand
  // is pre-shifted by two bits per iteration so the sum lands in place.
  always_comb begin
    booth_term = '0;
    case (mplr[2:0])
      3'b001, 3'b010: booth_term = mcand;
      3'b011:         booth_term = mcand << 1;
      3'b100:         booth_term = -(mcand << 1);
      3'b101, 3'b110: booth_term = -mcand;
      default:        booth_term = '0;
    endcase
    acc_next = acc + booth_term;
  end

  // One non-restoring step, plus the final correction and sign fix-up
  // used by FIX (quotient truncates, remainder follows the dividend).
  always_comb begin
    a_mag    = a[WIDTH-1] ? -a : a;
    b_mag    = b[WIDTH-1] ? -b : b;
    rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_step = rem[WIDTH] ? (rem_sh + {1'b0, dvsr}) : (rem_sh - {1'b0, dvsr});
    quo_step = {quo[WIDTH-2:0], ~rem_step[WIDTH]};
    rem_fix  = rem[WIDTH-1:0] + (rem[WIDTH] ? dvsr : '0);
    quo_res  = (a_neg ^ b_neg) ? -quo : quo;
    rem_res  = a_neg ? -rem_fix : rem_fix;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplr        <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      a_q         <= '0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      zhigh       <= '0;
      zlow        <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            a_q         <= a;
            a_neg       <= a[WIDTH-1];
            b_neg       <= b[WIDTH-1];
            acc         <= '0;
            mcand       <= {{(WIDTH + 1){a[WIDTH-1]}}, a};
            mplr        <= {b, 1'b0};
            rem         <= '0;
            quo         <= a_mag;
            dvsr        <= b_mag;
            state       <= op ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 2;
          mplr  <= {{2{mplr[WIDTH]}}, mplr[WIDTH:2]};
          cnt   <= cnt + CW'(1);
          if (cnt == MUL_LAST) begin
            zhigh <= acc_next[2*WIDTH-1:WIDTH];
            zlow  <= acc_next[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DIV: begin
          if (dvsr == '0) begin
            zlow        <= '1;
            zhigh       <= a_q;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + CW'(1);
            if (cnt == DIV_LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          zlow  <= quo_res;
          zhigh <= rem_res;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
